// File: rtl/lcd_req_arbiter.sv
// lcd_req_arbiter: round-robin arbiter and sequencer that shares one character-LCD controller
// among NREQ requesters. One 10-bit word {rs,rw,data} is issued at a time, then the LCD's
// per-command window is timed locally before the owner gets its ack pulse.
// Optional feature macro: LCD_ACCEPT_TIMEOUT_EN bounds the wait for the LCD accept to TO_CYC
// cycles and adds the sticky err output.
module lcd_req_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned HOLD_CYC = 52,
    parameter int unsigned TO_CYC   = 16,
    parameter int unsigned CW       = 10,
    localparam int unsigned IW      = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*10-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [IW-1:0]      grant_id,
    input  logic               lcd_busy,
    output logic               lcd_enable,
    output logic [9:0]         lcd_bus
`ifdef LCD_ACCEPT_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    // The shared counter has to reach both the hold and the timeout limits.
    if ((2 ** CW) <= ((HOLD_CYC > TO_CYC) ? HOLD_CYC : TO_CYC)) begin : g_cw_check
        $error("lcd_req_arbiter: CW too small for HOLD_CYC/TO_CYC");
    end

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAcc,
        StHold,
        StDone
    } state_e;

    localparam logic [CW-1:0] HoldLast = CW'(HOLD_CYC - 1);
`ifdef LCD_ACCEPT_TIMEOUT_EN
    localparam logic [CW-1:0] ToLast   = CW'(TO_CYC - 1);
`endif

    state_e          state_q;
    logic [IW-1:0]   grant_q;
    logic [9:0]      word_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] ack_q;
    logic            en_q;
    logic [9:0]      bus_q;
`ifdef LCD_ACCEPT_TIMEOUT_EN
    logic            err_q;
`endif

    logic [9:0]      words [NREQ];
    logic [NREQ-1:0] eligible;
    logic            pick_found;
    logic [IW-1:0]   pick_id;

    // Unpack the flat request bus into one word per requester.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            words[i] = req_data[10*i +: 10];
        end
    end

    // A requester whose ack is visible this cycle may not have dropped req yet; skip it once.
    assign eligible = req & ~ack_q;

    // Round-robin pick: first eligible requester scanning from grant_q+1 (mod NREQ).
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(grant_q) + k) % NREQ;
            if (!pick_found && eligible[IW'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = IW'(idx);
            end
        end
    end

    // Sequencer FSM; all outputs are registered and follow the state by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= IW'(NREQ - 1);
            word_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            bus_q   <= '0;
`ifdef LCD_ACCEPT_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            en_q  <= 1'b0;
            bus_q <= '0;
            ack_q <= '0;
            unique case (state_q)
                StIdle: begin
                    // lcd_busy high also covers the LCD power-up/init phase.
                    if (!lcd_busy && pick_found) begin
                        grant_q <= pick_id;
                        word_q  <= words[pick_id];
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    en_q    <= 1'b1;
                    bus_q   <= word_q;
                    cnt_q   <= '0;
                    state_q <= StWaitAcc;
                end
                StWaitAcc: begin
                    if (lcd_busy) begin
                        cnt_q   <= '0;
                        state_q <= StHold;
                    end
`ifdef LCD_ACCEPT_TIMEOUT_EN
                    else if (cnt_q == ToLast) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                StHold: begin
                    // The LCD drops busy early, so the command window is timed here.
                    if (cnt_q == HoldLast) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    ack_q[grant_q] <= 1'b1;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign grant_id   = grant_q;
    assign lcd_enable = en_q;
    assign lcd_bus    = bus_q;
`ifdef LCD_ACCEPT_TIMEOUT_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_lcd_req_arbiter.sv
// Self-checking bench for lcd_req_arbiter: directed scenarios plus randomized requesters,
// checked against a transaction-level round-robin model and an LCD behavioural model.
module tb_lcd_req_arbiter;

    localparam int NREQ     = 4;
    localparam int HOLD_CYC = 52;
    localparam int TO_CYC   = 16;
    localparam int CW       = 10;
    localparam int IW       = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*10-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic [IW-1:0]      grant_id;
    logic               lcd_busy;
    logic               lcd_enable;
    logic [9:0]         lcd_bus;
`ifdef LCD_ACCEPT_TIMEOUT_EN
    logic               err;
`endif

    lcd_req_arbiter #(
        .NREQ    (NREQ),
        .HOLD_CYC(HOLD_CYC),
        .TO_CYC  (TO_CYC),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant_id  (grant_id),
        .lcd_busy  (lcd_busy),
        .lcd_enable(lcd_enable),
        .lcd_bus   (lcd_bus)
`ifdef LCD_ACCEPT_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stimulus-side state.
    bit              lcd_init;
    bit              no_accept;
    int              busy_left;
    logic [NREQ-1:0] auto_drop;
    bit              en_prev;

    // Reference-model state.
    int                 last_owner = NREQ - 1;
    bit                 outstanding = 1'b0;
    int                 exp_ack_cyc;
    int                 exp_ack_id;
    int                 last_en_cyc;
    bit                 last_en_valid = 1'b0;
    logic [NREQ-1:0]    req_hist [4];
    logic [NREQ*10-1:0] data_hist [4];

    function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Model: the owner of each issue is the first requester pending at the grant edge, scanning
    // after the previous owner; its ack lands a fixed time after the issue strobe.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ack;
        logic [NREQ-1:0] pend;
        int              owner;
        req_hist[cyc & 3]  = req;
        data_hist[cyc & 3] = req_data;
        en_prev            = lcd_enable;
        if (!rst) begin
            last_owner    = NREQ - 1;
            outstanding   = 1'b0;
            last_en_valid = 1'b0;
        end
        exp_ack = '0;
        if (outstanding && cyc == exp_ack_cyc) begin
            exp_ack[exp_ack_id] = 1'b1;
            outstanding         = 1'b0;
        end
        check_eq("ack", ack, exp_ack);
        if (!lcd_enable) begin
            check_eq("bus_idle", lcd_bus, 0);
        end else begin
            check_eq("overlap", outstanding, 0);
            if (last_en_valid) check_eq("spacing", (cyc - last_en_cyc) >= HOLD_CYC + 4, 1);
            pend  = req_hist[(cyc - 2) & 3];
            owner = rr_pick(pend, last_owner);
            check_eq("enable_has_req", pend != '0, 1);
            if (owner >= 0) begin
                check_eq("grant_id", grant_id, owner);
                check_eq("bus", lcd_bus, data_hist[(cyc - 2) & 3][owner*10 +: 10]);
                last_owner    = owner;
                outstanding   = 1'b1;
                exp_ack_id    = owner;
                exp_ack_cyc   = cyc + (no_accept ? TO_CYC + 1 : HOLD_CYC + 3);
                last_en_cyc   = cyc;
                last_en_valid = 1'b1;
            end
        end
    end

    // One clock: LCD model reacts, requesters drop req on their ack.
    task automatic tick();
        @(posedge clk);
        #1;
        if (lcd_init) begin
            lcd_busy = 1'b1;
        end else if (no_accept) begin
            lcd_busy = 1'b0;
        end else if (en_prev) begin
            lcd_busy  = 1'b1;
            busy_left = $urandom_range(1, 70);
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) lcd_busy = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && auto_drop[i]) req[i] = 1'b0;
        end
    endtask

    task automatic wait_enable(input string tag, input int bound, output int c);
        c = -1;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (lcd_enable) begin
                c = cyc;
                return;
            end
        end
        check_eq({tag, "_timeout"}, lcd_enable, 1);
    endtask

    task automatic wait_ack(input string tag, input int idx, input int bound, output int c);
        c = -1;
        for (int n = 0; n < bound; n++) begin
            tick();
            if (ack[idx]) begin
                c = cyc;
                return;
            end
        end
        check_eq({tag, "_timeout"}, ack[idx], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        int         c1;
        int         cprev;
        int         k;
        logic [9:0] d;
        rst       = 1'b0;
        req       = '0;
        lcd_busy  = 1'b1;
        lcd_init  = 1'b1;
        no_accept = 1'b0;
        auto_drop = '1;
        busy_left = 0;
        for (int i = 0; i < NREQ; i++) req_data[10*i +: 10] = 10'($urandom);
        repeat (3) tick();
        check_eq("rst_ack", ack, 0);
        check_eq("rst_en", lcd_enable, 0);
        check_eq("rst_bus", lcd_bus, 0);
        check_eq("rst_gid", grant_id, NREQ - 1);
        rst = 1'b1;

        // LCD init: nothing issues while busy, then issue two cycles after busy falls.
        req_data[9:0] = 10'h2a5;
        req           = 4'b0001;
        for (int n = 0; n < 600; n++) begin
            tick();
            check_eq("t1_no_en_while_busy", lcd_enable, 0);
        end
        lcd_init = 1'b0;
        lcd_busy = 1'b0;
        k        = cyc;
        wait_enable("t1_en", 10, c0);
        check_eq("t1_latency", c0 - k, 2);
        check_eq("t1_bus", lcd_bus, 10'h2a5);
        wait_ack("t1_ack", 0, 100, c1);
        check_eq("t1_ack_lat", c1 - c0, HOLD_CYC + 3);

        // All four held: service order 0,1,2,3,0 from reset.
        repeat (80) tick();
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        auto_drop = '0;
        req       = '1;
        cprev     = 0;
        for (int j = 0; j < 5; j++) begin
            wait_enable("t2_en", 300, c0);
            check_eq("t2_order", grant_id, j % NREQ);
            if (j > 0) check_eq("t2_spacing", (c0 - cprev) >= 56, 1);
            cprev = c0;
        end
        req       = '0;
        auto_drop = '1;
        repeat (100) tick();

        // req dropped right after issue: transfer still completes and acks once.
        req_data[29:20] = 10'($urandom);
        req[2]          = 1'b1;
        wait_enable("t3_en", 300, c0);
        check_eq("t3_gid", grant_id, 2);
        tick();
        req[2] = 1'b0;
        wait_ack("t3_ack", 2, 100, c1);
        check_eq("t3_ack_lat", c1 - c0, 55);
        repeat (100) tick();

        // Asynchronous reset during HOLD, then the still-pending request is re-issued.
        req_data[19:10] = 10'($urandom);
        req[1]          = 1'b1;
        wait_enable("t4_en", 300, c0);
        repeat (10) tick();
        check_eq("t4_gid_pre", grant_id, 1);
        rst = 1'b0;
        #1;
        check_eq("t4_rst_en", lcd_enable, 0);
        check_eq("t4_rst_ack", ack, 0);
        check_eq("t4_rst_gid", grant_id, NREQ - 1);
        tick();
        rst = 1'b1;
        wait_enable("t4_reissue", 300, c0);
        check_eq("t4_reissue_gid", grant_id, 1);
        wait_ack("t4_ack", 1, 100, c1);
        repeat (100) tick();

        // Data changes after the grant edge and during HOLD do not reach the bus.
        d               = 10'($urandom);
        req_data[19:10] = d;
        req[1]          = 1'b1;
        tick();
        req_data[19:10] = ~d;
        wait_enable("t6_en", 10, c0);
        check_eq("t6_bus", lcd_bus, d);
        repeat (20) tick();
        req_data[19:10] = d ^ 10'h155;
        wait_ack("t6_ack", 1, 100, c1);
        check_eq("t6_ack_lat", c1 - c0, 55);

        // Random requesters; every issue and ack is checked by the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 39) == 0) begin
                        req_data[10*i +: 10] = 10'($urandom);
                        req[i]               = 1'b1;
                    end else if ($urandom_range(0, 7) == 0) begin
                        req_data[10*i +: 10] = 10'($urandom);
                    end
                end
            end
        end
        for (int n = 0; n < 2000 && req != '0; n++) tick();
        check_eq("drain", req, 0);
        repeat (100) tick();

`ifdef LCD_ACCEPT_TIMEOUT_EN
        // LCD never accepts: timeout acks and sets the sticky err.
        check_eq("t5_err_clear", err, 0);
        no_accept = 1'b1;
        lcd_busy  = 1'b0;
        busy_left = 0;
        req[0]    = 1'b1;
        wait_enable("t5_en", 300, c0);
        wait_ack("t5_ack", 0, 100, c1);
        check_eq("t5_ack_lat", c1 - c0, TO_CYC + 1);
        check_eq("t5_err", err, 1);
        repeat (20) tick();
        check_eq("t5_err_sticky", err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
